shift_feeder: RTL and testbench

//   Upstream stage of the 8-bit shift register top level. Accepts bytes on a valid/ready

---
 rtl/shift_feeder_pkg.sv | 19 +
 rtl/shift_feeder_fifo.sv | 62 ++++++
 rtl/shift_feeder.sv | 167 ++++++++++++++++
 tb/tb_shift_feeder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_feeder_pkg.sv
// Shared definitions for the shift_feeder block: FSM state encoding, default byte width
// and shift-counter width.
package shift_feeder_pkg;

   // Frame sequencing states of the feeder
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Default byte width, matching the downstream shift stage
   localparam int unsigned DEF_DATA_W = 8;

   // Shift counter width; covers SHIFT_CYCLES up to 255
   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/shift_feeder_fifo.sv
// Small power-of-two FIFO for shift_feeder. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without an occupancy counter. Read data is the
// current head, visible combinationally.
module shift_feeder_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   // Full when the wrap bits differ but the index bits match; empty when identical
   always_comb begin
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty = (wr_ptr_q == rd_ptr_q);
   end

   // Guard against overflow/underflow even if a caller misbehaves
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
   end

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written, so it carries no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   // Head of queue
   always_comb begin
      pop_data = mem_q[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/shift_feeder.sv
// shift_feeder: buffers producer bytes in a FIFO and runs one downstream shift frame per
// byte: present byte on m with a load pulse, hold en for SHIFT_CYCLES cycles, then pulse
// frame_done. All outputs are registered.
// Optional feature: define SHIFT_FEEDER_PARITY_EN to add a registered parity output (^m).
module shift_feeder
   import shift_feeder_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned SHIFT_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] m,
   output logic              load,
   output logic              en,
   output logic              busy,
   output logic              frame_done
`ifdef SHIFT_FEEDER_PARITY_EN
   ,
   output logic              parity
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] m_q, m_d;
   logic              load_q, load_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              fd_q, fd_d;

   logic              push, pop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   // Producer handshake; ready is held low while reset is asserted
   always_comb begin
      in_ready = rst & ~fifo_full;
      push     = in_valid & in_ready;
   end

   shift_feeder_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // State register and frame counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; a FIFO pop happens only on the transition into LOAD
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_LOAD;
               pop     = 1'b1;
            end
         end
         S_LOAD: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // Back-to-back frames go straight to LOAD without passing through IDLE
            if (!fifo_empty) begin
               state_d = S_LOAD;
               pop     = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output next values, decoded from the next state so the outputs come out registered
   always_comb begin
      m_d    = pop ? fifo_head : m_q;
      load_d = (state_d == S_LOAD);
      en_d   = (state_d == S_SHIFT);
      fd_d   = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q    <= '0;
         load_q <= 1'b0;
         en_q   <= 1'b0;
         fd_q   <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         m_q    <= m_d;
         load_q <= load_d;
         en_q   <= en_d;
         fd_q   <= fd_d;
         busy_q <= busy_d;
      end
   end

   // Drive ports from the output registers
   always_comb begin
      m          = m_q;
      load       = load_q;
      en         = en_q;
      busy       = busy_q;
      frame_done = fd_q;
   end

`ifdef SHIFT_FEEDER_PARITY_EN
   logic parity_q, parity_d;

   // Parity tracks m: computed from the byte being popped, so it lands on the same edge
   always_comb begin
      parity_d = pop ? ^fifo_head : parity_q;
   end

   // Parity register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   // Parity port
   always_comb begin
      parity = parity_q;
   end
`endif

endmodule

// File: tb/tb_shift_feeder.sv
// Self-checking bench for shift_feeder: table-driven single-byte frames, hand-written
// multi-cycle sequences, and a scoreboard queue checking every loaded byte in order.
// Define SHIFT_FEEDER_PARITY_EN to also check the parity output.
module tb_shift_feeder;
   import shift_feeder_pkg::*;

   localparam int unsigned SC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] m;
   logic       load, en, busy, frame_done;
`ifdef SHIFT_FEEDER_PARITY_EN
   logic       parity;
`endif

   shift_feeder #(
      .DATA_W       (8),
      .DEPTH        (4),
      .SHIFT_CYCLES (SC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .m          (m),
      .load       (load),
      .en         (en),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef SHIFT_FEEDER_PARITY_EN
      ,
      .parity     (parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       exp_par;
   } vec_t;

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         en_run = 0;
   int         frames = 0;
   logic       prev_fd = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle output monitor: scoreboard pop on load, en burst length, pulse width
   task automatic monitor();
      logic [7:0] e;
      if (load) begin
         if (exp_q.size() == 0) begin
            check("load_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_m", {24'h0, m}, {24'h0, e});
`ifdef SHIFT_FEEDER_PARITY_EN
            check("sb_parity", {31'h0, parity}, {31'h0, ^e});
`endif
            check("load_en_low", {31'h0, en}, 0);
         end
      end
      if (en) en_run++;
      if (frame_done) begin
         frames++;
         check("en_run_len", en_run, SC);
         check("fd_pulse", {31'h0, prev_fd}, 0);
         en_run = 0;
      end
      prev_fd = frame_done;
   endtask

   // One clock: record accepted bytes, then sample 1 time unit after the edge
   task automatic step();
      logic       acc;
      logic [7:0] d;
      acc = in_valid && in_ready;
      d   = in_data;
      @(posedge clk);
      if (acc) exp_q.push_back(d);
      #1;
      monitor();
   endtask

   function automatic logic cond(input int which);
      case (which)
         0:       return en;
         1:       return frame_done;
         2:       return load;
         default: return !busy && (exp_q.size() == 0);
      endcase
   endfunction

   task automatic wait_until(input int which, input string name, input int limit);
      int n = 0;
      while (!cond(which) && n < limit) begin
         step();
         n++;
      end
      if (!cond(which)) check(name, 0, 1);
   endtask

   task automatic push1(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      vec_t vecs[7];
      int   n, g, fb, sent, guard;
      logic saw_busy, saw_fd;

      vecs[0] = '{8'hAA, 1'b0};
      vecs[1] = '{8'h07, 1'b1};
      vecs[2] = '{8'h03, 1'b0};
      vecs[3] = '{8'h80, 1'b1};
      vecs[4] = '{8'hFF, 1'b0};
      vecs[5] = '{8'h5A, 1'b0};
      vecs[6] = '{8'hE5, 1'b1};

      // Reset state
      #2;
      check("rst_en", {31'h0, en}, 0);
      check("rst_load", {31'h0, load}, 0);
      check("rst_busy", {31'h0, busy}, 0);
      check("rst_fd", {31'h0, frame_done}, 0);
      check("rst_m", {24'h0, m}, 0);
      check("rst_ready", {31'h0, in_ready}, 0);
      step();
      step();
      rst = 1'b1;
      step();
      check("rel_ready", {31'h0, in_ready}, 1);

      // Single byte, cycle-exact
      push1(8'hAA);
      check("t2_load_e0", {31'h0, load}, 0);
      check("t2_busy_e0", {31'h0, busy}, 0);
      step();
      check("t2_load", {31'h0, load}, 1);
      check("t2_m", {24'h0, m}, 32'hAA);
      check("t2_busy", {31'h0, busy}, 1);
      for (int i = 0; i < int'(SC); i++) begin
         step();
         check("t2_en_hi", {31'h0, en}, 1);
         check("t2_fd_lo", {31'h0, frame_done}, 0);
      end
      step();
      check("t2_en_lo", {31'h0, en}, 0);
      check("t2_fd", {31'h0, frame_done}, 1);
      step();
      check("t2_fd_off", {31'h0, frame_done}, 0);
      check("t2_idle", {31'h0, busy}, 0);
      check("t2_m_hold", {24'h0, m}, 32'hAA);

      // Table of single-byte frames (m and parity)
      for (int i = 0; i < 7; i++) begin
         push1(vecs[i].data);
         wait_until(2, "tbl_load_timeout", 10);
         check("tbl_m", {24'h0, m}, {24'h0, vecs[i].data});
`ifdef SHIFT_FEEDER_PARITY_EN
         check("tbl_parity", {31'h0, parity}, {31'h0, vecs[i].exp_par});
`endif
         wait_until(3, "tbl_idle_timeout", 40);
      end

      // Mid-frame reset aborts the frame
      push1(8'h55);
      wait_until(0, "t1_en_timeout", 10);
      step();
      step();
      rst = 1'b0;
      #1;
      check("t1_en", {31'h0, en}, 0);
      check("t1_load", {31'h0, load}, 0);
      check("t1_busy", {31'h0, busy}, 0);
      check("t1_m", {24'h0, m}, 0);
      check("t1_ready", {31'h0, in_ready}, 0);
      exp_q.delete();
      en_run  = 0;
      prev_fd = 1'b0;
      step();
      step();
      rst = 1'b1;
      saw_busy = 1'b0;
      saw_fd   = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         saw_busy |= busy;
         saw_fd   |= frame_done;
      end
      check("t1_no_busy", {31'h0, saw_busy}, 0);
      check("t1_no_fd", {31'h0, saw_fd}, 0);
      check("t1_ready_rel", {31'h0, in_ready}, 1);

      // Fill the FIFO while a frame is running
      fb = frames;
      push1(8'hF0);
      wait_until(0, "t3_en_timeout", 10);
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         check("t3_ready_free", {31'h0, in_ready}, 1);
         step();
      end
      in_data = 8'h05;
      check("t3_full", {31'h0, in_ready}, 0);
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("t3_ready_back", {31'h0, in_ready}, 1);
      check("t3_ready_at_load", {31'h0, load}, 1);
      step();
      in_valid = 1'b0;
      wait_until(3, "t3_drain_timeout", 200);
      check("t3_frames", frames - fb, 6);

      // Back-to-back frames: two en-low cycles between bursts
      push1(8'h3C);
      push1(8'hC3);
      wait_until(0, "t4_en_timeout", 10);
      n = 0;
      while (en && n < 50) begin
         step();
         n++;
      end
      check("t4_burst1", n, SC);
      g = 0;
      while (!en && g < 50) begin
         step();
         g++;
      end
      check("t4_gap", g, 2);
      wait_until(3, "t4_drain_timeout", 60);

      // Push and pop on the same edge with occupancy 2
      push1(8'hA1);
      push1(8'hA2);
      push1(8'hA3);
      wait_until(1, "t5_fd_timeout", 30);
      in_valid = 1'b1;
      in_data  = 8'hA4;
      check("t5_ready_pp", {31'h0, in_ready}, 1);
      step();
      check("t5_load_pp", {31'h0, load}, 1);
      check("t5_m_pp", {24'h0, m}, 32'hA2);
      in_data = 8'hB1;
      step();
      check("t5_ready_occ3", {31'h0, in_ready}, 1);
      in_data = 8'hB2;
      step();
      check("t5_full_occ4", {31'h0, in_ready}, 0);
      in_valid = 1'b0;
      wait_until(3, "t5_drain_timeout", 200);

      // Random valid over many pointer wraps
      fb    = frames;
      sent  = 0;
      guard = 0;
      while (sent < 40 && guard < 3000) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         if (in_valid && in_ready) sent++;
         step();
         guard++;
      end
      in_valid = 1'b0;
      check("rand_sent", sent, 40);
      wait_until(3, "rand_drain_timeout", 600);
      check("rand_frames", frames - fb, 40);
      check("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
